// File: rtl/lcd_stim_pkg.sv
// Shared types and defaults for the LCD stimulus sequencer.
// Holds the playback state encoding and buffer pointer sizing.
package lcd_stim_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    localparam int DEPTH_DEF       = 16;
    localparam int GAP_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 65535;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/lcd_stim_fifo.sv
// Command buffer of {rs, data} entries with flush and rotate.
// Rotate re-queues the popped head at the tail for looped playback.
module lcd_stim_fifo
    import lcd_stim_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdat,
    input  logic         i_pop,
    input  logic         i_rot,
    input  logic         i_flush,
    output logic [W-1:0] o_rdat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    logic          w_pop;
    logic          w_push;
    logic [W-1:0]  w_wdat;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_rdat  = r_mem[r_rp];

    assign w_pop  = i_pop && !o_empty && !i_flush;
    // A rotating pop occupies the write port; a same-cycle external write is dropped
    assign w_push = !i_flush &&
                    ((w_pop && i_rot) || (i_wr && (!o_full || w_pop)));
    assign w_wdat = (w_pop && i_rot) ? o_rdat : i_wdat;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/lcd_stim_sequencer.sv
// Plays buffered {rs, data} commands to an LCD controller with done/timeout.
// LCD_STIM_LOOP_EN adds loop_mode for non-destructive repeating playback.
module lcd_stim_sequencer
    import lcd_stim_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int DATA_W      = 8,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_rs,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    input  logic              lcd_done,
`ifdef LCD_STIM_LOOP_EN
    input  logic              loop_mode,
`endif
    output logic              lcd_rs,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_strobe,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic [15:0]       done_cnt,
    output logic              timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t            r_state;
    logic [TW-1:0]     r_tmr;
    logic [GW-1:0]     r_gap;
    logic              r_rs;
    logic [DATA_W-1:0] r_data;
    logic              r_strobe;
    logic [15:0]       r_done_cnt;
    logic              r_tmo_err;

    logic              w_pop;
    logic              w_rot;
    logic              w_tmo;
    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W:0]   w_head;

    assign w_pop   = (r_state == S_ISSUE) && !abort;
    assign w_tmo   = (r_state == S_WAIT) && !lcd_done &&
                     (r_tmr == TW'(TIMEOUT_CYC - 1));
    assign w_flush = abort || w_tmo;
`ifdef LCD_STIM_LOOP_EN
    assign w_rot   = loop_mode;
`else
    assign w_rot   = 1'b0;
`endif

    lcd_stim_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (wr_en),
        .i_wdat  ({wr_rs, wr_data}),
        .i_pop   (w_pop),
        .i_rot   (w_rot),
        .i_flush (w_flush),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_gap      <= '0;
            r_rs       <= 1'b0;
            r_data     <= '0;
            r_strobe   <= 1'b0;
            r_done_cnt <= '0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (start && !abort) r_tmo_err <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !w_empty) r_state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        r_rs     <= w_head[DATA_W];
                        r_data   <= w_head[DATA_W-1:0];
                        r_strobe <= 1'b1;
                        r_tmr    <= '0;
                        r_state  <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lcd_done) begin
                            if (r_done_cnt != 16'hFFFF)
                                r_done_cnt <= r_done_cnt + 16'd1;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end else if (w_tmo) begin
                            r_tmo_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_tmr <= r_tmr + TW'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GW'(GAP_CYC - 1))
                            r_state <= w_empty ? S_IDLE : S_ISSUE;
                        else
                            r_gap <= r_gap + GW'(1);
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign lcd_rs      = r_rs;
    assign lcd_data    = r_data;
    assign lcd_strobe  = r_strobe;
    assign full        = w_full;
    assign empty       = w_empty;
    assign busy        = (r_state != S_IDLE);
    assign done_cnt    = r_done_cnt;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_lcd_stim_sequencer.sv
// Directed bench for lcd_stim_sequencer (DEPTH=16, GAP_CYC=4, TIMEOUT_CYC=100).
// Define LCD_STIM_LOOP_EN to also exercise looped playback.
module tb_lcd_stim_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_rs = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lcd_done = 1'b0;
`ifdef LCD_STIM_LOOP_EN
    logic        loop_mode = 1'b0;
`endif
    logic        lcd_rs;
    logic [7:0]  lcd_data;
    logic        lcd_strobe;
    logic        full;
    logic        empty;
    logic        busy;
    logic [15:0] done_cnt;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    lcd_stim_sequencer #(
        .DEPTH       (16),
        .DATA_W      (8),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_rs       (wr_rs),
        .wr_data     (wr_data),
        .start       (start),
        .abort       (abort),
        .lcd_done    (lcd_done),
`ifdef LCD_STIM_LOOP_EN
        .loop_mode   (loop_mode),
`endif
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data),
        .lcd_strobe  (lcd_strobe),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .done_cnt    (done_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        wr_en = 1'b1;
        wr_rs = rs;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        while (lcd_strobe !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic serve(input string tag, input logic rs,
                         input logic [7:0] d);
        int n;
        wait_strobe(40, n);
        check({tag, "_seen"}, lcd_strobe, 1);
        check({tag, "_rs"}, lcd_rs, rs);
        check({tag, "_data"}, lcd_data, d);
        @(negedge clk);
        check({tag, "_1cyc"}, lcd_strobe, 0);
        repeat (9) @(negedge clk);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        #2;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", lcd_strobe, 0);
        check("rst_cnt", done_cnt, 0);
        check("rst_err", timeout_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Two commands, done 10 clocks after each strobe
        push(1'b0, 8'h28);
        push(1'b1, 8'h41);
        check("two_empty", empty, 0);
        pulse_start();
        check("lat_issue", lcd_strobe, 0);
        check("lat_busy", busy, 1);
        @(negedge clk);
        check("lat_strobe", lcd_strobe, 1);
        serve("c0", 1'b0, 8'h28);
        serve("c1", 1'b1, 8'h41);
        repeat (6) @(negedge clk);
        check("two_busy", busy, 0);
        check("two_empty_end", empty, 1);
        check("two_cnt", done_cnt, 2);

        // Fill to 16, 17th dropped
        for (int i = 0; i < 16; i++) begin
            push(i[0], 8'(i + 8'h60));
            if (i == 14) check("full_at15", full, 0);
        end
        check("full_at16", full, 1);
        push(1'b1, 8'hEE);
        check("full_17", full, 1);
        pulse_start();
        for (int i = 0; i < 16; i++)
            serve($sformatf("f%0d", i), i[0], 8'(i + 8'h60));
        wait_strobe(30, n);
        check("f_no_17th", n, 30);
        check("f_cnt", done_cnt, 18);
        check("f_empty", empty, 1);

        // Timeout on withheld done
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        pulse_start();
        wait_strobe(5, n);
        check("t_seen", lcd_strobe, 1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t_clk", k, 100);
        check("t_busy", busy, 0);
        check("t_empty", empty, 1);
        check("t_cnt", done_cnt, 18);
        pulse_start();
        check("t_clear", timeout_err, 0);
        check("t_start_empty", busy, 0);

        // Abort during GAP with 3 queued
        push(1'b0, 8'h31);
        push(1'b0, 8'h32);
        push(1'b0, 8'h33);
        push(1'b0, 8'h34);
        pulse_start();
        serve("a0", 1'b0, 8'h31);
        check("a_in_gap", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("a_busy", busy, 0);
        check("a_empty", empty, 1);
        wait_strobe(30, n);
        check("a_no_strobe", n, 30);
        check("a_cnt", done_cnt, 19);

        // Async reset mid-WAIT
        push(1'b1, 8'h55);
        push(1'b0, 8'h56);
        pulse_start();
        wait_strobe(5, n);
        repeat (3) @(negedge clk);
        check("r_pre_data", lcd_data, 8'h55);
        #2 rst = 1'b0;
        #1;
        check("r_data", lcd_data, 0);
        check("r_rs", lcd_rs, 0);
        check("r_busy", busy, 0);
        check("r_cnt", done_cnt, 0);
        check("r_empty", empty, 1);
        check("r_strobe", lcd_strobe, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_strobe(20, n);
        check("r_no_strobe", n, 20);

`ifdef LCD_STIM_LOOP_EN
        loop_mode = 1'b1;
        push(1'b0, 8'hA1);
        push(1'b1, 8'hB2);
        push(1'b0, 8'hC3);
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            serve($sformatf("lA%0d", r), 1'b0, 8'hA1);
            serve($sformatf("lB%0d", r), 1'b1, 8'hB2);
            serve($sformatf("lC%0d", r), 1'b0, 8'hC3);
        end
        check("l_kept", empty, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        loop_mode = 1'b0;
        check("l_busy", busy, 0);
        check("l_empty", empty, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_stim_sequencer.md
LCD_STIM_SEQUENCER -- requirements
Module: lcd_stim_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, command buffer depth in entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 8, command data width.
REQ-003 SHALL have parameter GAP_CYC, default 4, idle clocks inserted between consecutive commands; minimum 1.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535, maximum clocks to wait for done.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, pushes {wr_rs, wr_data} into the buffer.
REQ-008 SHALL have port wr_rs, input, 1, register-select bit of the pushed command.
REQ-009 SHALL have port wr_data, input, DATA_W, data of the pushed command.
REQ-010 SHALL have port start, input, 1, begins playback.
REQ-011 SHALL have port abort, input, 1, stops playback and flushes the buffer.
REQ-012 SHALL have port lcd_done, input, 1, completion pulse from the LCD controller.
REQ-013 SHALL have port lcd_rs, output, 1, register select to the controller.
REQ-014 SHALL have port lcd_data, output, DATA_W, data to the controller.
REQ-015 SHALL have port lcd_strobe, output, 1, one-clock command strobe.
REQ-016 SHALL have ports full and empty, outputs, 1 each, buffer status.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-018 SHALL have port done_cnt, output, 16, completed commands since reset; saturates at 16'hFFFF.
REQ-019 SHALL have port timeout_err, output, 1, sticky timeout flag.

Function
REQ-020 SHALL implement a DEPTH-entry FIFO of {rs, data}, with occupancy counter width clog2(DEPTH)+1.
REQ-021 SHALL ignore wr_en when full and no pop occurs in the same cycle; a write and a pop in the same cycle SHALL both take effect.
REQ-022 SHALL implement the states IDLE, ISSUE, WAIT and GAP.
REQ-023 IDLE: start=1 with the buffer non-empty SHALL go to ISSUE next cycle; start with the buffer empty SHALL be ignored.
REQ-024 ISSUE: SHALL pop the head, register it onto lcd_rs/lcd_data, assert lcd_strobe for exactly one cycle, then go to WAIT.
REQ-025 lcd_rs/lcd_data SHALL hold their value until the next ISSUE.
REQ-026 WAIT: lcd_done=1 SHALL increment done_cnt and go to GAP; an lcd_done in any other state SHALL be ignored.
REQ-027 WAIT: after TIMEOUT_CYC clocks without lcd_done, SHALL set timeout_err, flush the buffer and go to IDLE.
REQ-028 GAP: SHALL count GAP_CYC clocks, then go to ISSUE if the buffer is non-empty, else to IDLE.
REQ-029 Command-to-strobe latency from IDLE SHALL be 2 clocks after start is sampled.
REQ-030 abort SHALL have priority over every other event: the next state is IDLE and the buffer is empty; done_cnt and timeout_err are kept.
REQ-031 timeout_err SHALL clear only on reset or on start.

Reset
REQ-032 When rst=0, all state SHALL clear asynchronously: state IDLE, buffer empty, lcd_strobe=0, lcd_rs=0, lcd_data=0, busy=0, done_cnt=0, timeout_err=0, empty=1, full=0.
REQ-033 On rst release, the block SHALL be operational from the first clock edge.
REQ-034 Reset mid-WAIT SHALL discard the outstanding command with no strobe emitted.

Configuration
REQ-035 With LCD_STIM_LOOP_EN defined, an input loop_mode SHALL exist; when it is high, playback SHALL be non-destructive: entries are retained and the read pointer wraps to the first loaded entry after the last, repeating until abort.
REQ-036 Without LCD_STIM_LOOP_EN, loop_mode SHALL be absent and playback SHALL always pop destructively.

Structure
REQ-037 The state enum, the DEPTH-derived pointer width, and the defaults GAP_CYC and TIMEOUT_CYC SHALL reside in package lcd_stim_pkg.
REQ-038 The FIFO SHALL be a sub-module named lcd_stim_fifo; the state machine and counters SHALL stay in lcd_stim_sequencer.

Verification
REQ-039 Push (0,0x28),(1,0x41), then start; respond to each strobe with done after 10 clocks -> two strobes carrying exactly those values, done_cnt=2, then IDLE and empty=1.
REQ-040 Push 17 entries with DEPTH=16 -> full=1 after the 16th; the 17th is dropped; 16 strobes are played.
REQ-041 Withhold lcd_done with TIMEOUT_CYC=100 -> timeout_err=1 at clock 100 of WAIT, buffer flushed, busy=0.
REQ-042 Assert abort during GAP with 3 entries queued -> IDLE next cycle, empty=1, no further strobe.
REQ-043 Assert rst=0 mid-WAIT -> all outputs at reset values immediately, without a clock edge.
REQ-044 With LCD_STIM_LOOP_EN defined and loop_mode=1, load 3 entries and start -> strobes repeat A,B,C,A,B,C until abort.
